// File: rtl/ingress_queue.sv
// ingress_queue: per-ingress-port store-and-forward packet buffer feeding the egress schedulers.
// Define INGRESS_DROP_EN to drop packets that overflow the buffer (adds drop_count) instead of backpressuring.
module ingress_queue #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 2,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [IDX_WIDTH-1:0]  in_dst,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [IDX_WIDTH-1:0]  out_dst,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   pkt_count
`ifdef INGRESS_DROP_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IN_HEAD = 2'd0,
        IN_BODY = 2'd1
`ifdef INGRESS_DROP_EN
        ,
        IN_DROP = 2'd2
`endif
    } in_state_e;

    in_state_e state_q;
    in_state_e state_d;

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic                  mem_last [DEPTH];
    logic [IDX_WIDTH-1:0]  desc_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] d_wr_ptr;
    logic [PTR_W-1:0] d_rd_ptr;

    logic full;
    logic accept;
    logic desc_wr;
    logic commit;
    logic rd_fire;
    logic pop;

`ifdef INGRESS_DROP_EN
    logic [PTR_W-1:0] commit_ptr;
    logic             drop_start;
`endif

    assign full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    // Head presentation: gated so everything reads zero while no complete packet is stored
    assign out_valid = (pkt_count != CNT_W'(0));
    assign out_data  = out_valid ? mem_data[rd_ptr[ADDR_WIDTH-1:0]] : '0;
    assign out_last  = out_valid & mem_last[rd_ptr[ADDR_WIDTH-1:0]];
    assign out_dst   = out_valid ? desc_mem[d_rd_ptr[ADDR_WIDTH-1:0]] : '0;

    assign rd_fire = out_valid && out_ready;
    assign pop     = rd_fire && out_last;
    assign commit  = accept && in_last;

    // Input FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IN_HEAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Input FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IN_HEAD: if (accept && !in_last) state_d = IN_BODY;
            IN_BODY: if (accept && in_last)  state_d = IN_HEAD;
`ifdef INGRESS_DROP_EN
            IN_DROP: if (in_valid && in_last) state_d = IN_HEAD;
`endif
            default: state_d = IN_HEAD;
        endcase
`ifdef INGRESS_DROP_EN
        if (drop_start) state_d = in_last ? IN_HEAD : IN_DROP;
`endif
    end

    // Input FSM outputs: acceptance, descriptor write, drop trigger
    always_comb begin
        in_ready = 1'b1;
        accept   = 1'b0;
        desc_wr  = 1'b0;
`ifdef INGRESS_DROP_EN
        drop_start = in_valid && full && (state_q != IN_DROP);
        accept     = in_valid && !full && (state_q != IN_DROP);
`else
        in_ready = !full;
        accept   = in_valid && !full;
`endif
        desc_wr = accept && (state_q == IN_HEAD);
    end

    // Pointers and packet count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            d_wr_ptr   <= '0;
            d_rd_ptr   <= '0;
            pkt_count  <= '0;
`ifdef INGRESS_DROP_EN
            commit_ptr <= '0;
            drop_count <= '0;
`endif
        end else begin
            if (accept)  wr_ptr   <= wr_ptr + PTR_W'(1);
            if (desc_wr) d_wr_ptr <= d_wr_ptr + PTR_W'(1);
            if (rd_fire) rd_ptr   <= rd_ptr + PTR_W'(1);
            if (pop)     d_rd_ptr <= d_rd_ptr + PTR_W'(1);
            pkt_count <= pkt_count + CNT_W'(commit) - CNT_W'(pop);
`ifdef INGRESS_DROP_EN
            if (desc_wr) commit_ptr <= wr_ptr;
            // Overflow: discard the partial packet and its descriptor
            if (drop_start) begin
                if (state_q == IN_BODY) begin
                    wr_ptr   <= commit_ptr;
                    d_wr_ptr <= d_wr_ptr - PTR_W'(1);
                end
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
`endif
        end
    end

    // Beat and descriptor storage
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
            mem_last[wr_ptr[ADDR_WIDTH-1:0]] <= in_last;
        end
        if (desc_wr) begin
            desc_mem[d_wr_ptr[ADDR_WIDTH-1:0]] <= in_dst;
        end
    end

endmodule

// File: tb/tb_ingress_queue.sv
// Directed self-checking bench for ingress_queue (DEPTH=16); exercises INGRESS_DROP_EN when defined.
module tb_ingress_queue;

    logic       clk;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic [1:0] in_dst;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic [1:0] out_dst;
    logic       out_ready;
    logic [4:0] pkt_count;
`ifdef INGRESS_DROP_EN
    logic [15:0] drop_count;
`endif

    int vectors;
    int miscompares;

    ingress_queue dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_dst    (in_dst),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_dst   (out_dst),
        .out_ready (out_ready),
        .pkt_count (pkt_count)
`ifdef INGRESS_DROP_EN
        ,
        .drop_count(drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic [1:0] dst, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_dst   = dst;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        in_dst    = 2'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        vectors++; if (out_dst !== 2'd0) begin miscompares++; $display("FAIL reset_out_dst: got %0d want 0", out_dst); end
        vectors++; if (pkt_count !== 5'd0) begin miscompares++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
`ifdef INGRESS_DROP_EN
        vectors++; if (drop_count !== 16'd0) begin miscompares++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_beat();
        out_ready = 1'b1;
        send_beat(8'hA5, 2'd2, 1'b1);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", out_valid); end
        vectors++; if (out_data !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h want a5", out_data); end
        vectors++; if (out_dst !== 2'd2) begin miscompares++; $display("FAIL single_dst: got %0d want 2", out_dst); end
        vectors++; if (out_last !== 1'b1) begin miscompares++; $display("FAIL single_last: got %b want 1", out_last); end
        vectors++; if (pkt_count !== 5'd1) begin miscompares++; $display("FAIL single_count1: got %0d want 1", pkt_count); end
        step();
        vectors++; if (pkt_count !== 5'd0) begin miscompares++; $display("FAIL single_count0: got %0d want 0", pkt_count); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_after: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_data;
        logic [1:0] exp_dst;
        logic       exp_last;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(8'h10 + 8'(i), 2'd1, i == 2);
        for (int i = 0; i < 3; i++) send_beat(8'h20 + 8'(i), 2'd3, i == 2);
        vectors++; if (pkt_count !== 5'd2) begin miscompares++; $display("FAIL b2b_count: got %0d want 2", pkt_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_data = (i < 3) ? 8'h10 + 8'(i) : 8'h20 + 8'(i - 3);
            exp_dst  = (i < 3) ? 2'd1 : 2'd3;
            exp_last = (i == 2) || (i == 5);
            vectors++; if (out_data !== exp_data) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data, exp_data); end
            vectors++; if (out_dst !== exp_dst) begin miscompares++; $display("FAIL b2b_dst[%0d]: got %0d want %0d", i, out_dst, exp_dst); end
            vectors++; if (out_last !== exp_last) begin miscompares++; $display("FAIL b2b_last[%0d]: got %b want %b", i, out_last, exp_last); end
            step();
        end
        out_ready = 1'b0;
        vectors++; if (pkt_count !== 5'd0) begin miscompares++; $display("FAIL b2b_drained: got %0d want 0", pkt_count); end
    endtask

    task automatic test_fill_wrap();
        logic exp_ready_full;
        logic [7:0] exp_data;
`ifdef INGRESS_DROP_EN
        exp_ready_full = 1'b1;
`else
        exp_ready_full = 1'b0;
`endif
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_pre: got %b want 1", in_ready); end
            end
            send_beat(8'(i), 2'(i / 4), (i % 4) == 3);
        end
        vectors++; if (in_ready !== exp_ready_full) begin miscompares++; $display("FAIL fill_ready_full: got %b want %b", in_ready, exp_ready_full); end
        vectors++; if (pkt_count !== 5'd4) begin miscompares++; $display("FAIL fill_count: got %0d want 4", pkt_count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_freed: got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            vectors++; if (out_data !== 8'(i)) begin miscompares++; $display("FAIL fill_data[%0d]: got %h want %h", i, out_data, 8'(i)); end
            vectors++; if (out_dst !== 2'(i / 4)) begin miscompares++; $display("FAIL fill_dst[%0d]: got %0d want %0d", i, out_dst, i / 4); end
            vectors++; if (out_last !== ((i % 4) == 3)) begin miscompares++; $display("FAIL fill_last[%0d]: got %b", i, out_last); end
            step();
        end
        out_ready = 1'b0;
        vectors++; if (pkt_count !== 5'd0) begin miscompares++; $display("FAIL fill_drained: got %0d want 0", pkt_count); end
        // 32 further beats carry both pointers through two more wraps
        for (int k = 0; k < 8; k++) begin
            for (int b = 0; b < 4; b++) send_beat(8'h40 + 8'(k * 4 + b), 2'(k % 4), b == 3);
            out_ready = 1'b1;
            for (int b = 0; b < 4; b++) begin
                exp_data = 8'h40 + 8'(k * 4 + b);
                vectors++; if (out_data !== exp_data || out_dst !== 2'(k % 4)) begin miscompares++; $display("FAIL wrap_beat[%0d]: got %h/%0d want %h/%0d", k * 4 + b, out_data, out_dst, exp_data, k % 4); end
                step();
            end
            out_ready = 1'b0;
        end
        vectors++; if (pkt_count !== 5'd0) begin miscompares++; $display("FAIL wrap_drained: got %0d want 0", pkt_count); end
    endtask

    task automatic test_collide();
        out_ready = 1'b0;
        send_beat(8'h61, 2'd1, 1'b0);
        send_beat(8'h62, 2'd1, 1'b1);
        send_beat(8'h71, 2'd2, 1'b0);
        out_ready = 1'b1;
        step();
        vectors++; if (out_data !== 8'h62 || out_last !== 1'b1) begin miscompares++; $display("FAIL collide_a_last: got %h/%b want 62/1", out_data, out_last); end
        send_beat(8'h72, 2'd2, 1'b1);
        vectors++; if (pkt_count !== 5'd1) begin miscompares++; $display("FAIL collide_count: got %0d want 1", pkt_count); end
        vectors++; if (out_dst !== 2'd2) begin miscompares++; $display("FAIL collide_dst: got %0d want 2", out_dst); end
        vectors++; if (out_data !== 8'h71 || out_last !== 1'b0) begin miscompares++; $display("FAIL collide_b0: got %h/%b want 71/0", out_data, out_last); end
        step();
        vectors++; if (out_data !== 8'h72 || out_last !== 1'b1) begin miscompares++; $display("FAIL collide_b1: got %h/%b want 72/1", out_data, out_last); end
        step();
        out_ready = 1'b0;
        vectors++; if (pkt_count !== 5'd0) begin miscompares++; $display("FAIL collide_drained: got %0d want 0", pkt_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_beat(8'h81, 2'd3, 1'b1);
        send_beat(8'h91, 2'd0, 1'b0);
        send_beat(8'h92, 2'd0, 1'b0);
        vectors++; if (pkt_count !== 5'd1) begin miscompares++; $display("FAIL rstmid_pre_count: got %0d want 1", pkt_count); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || pkt_count !== 5'd0) begin miscompares++; $display("FAIL rstmid_async: got valid %b count %0d want 0/0", out_valid, pkt_count); end
        vectors++; if (in_ready !== 1'b1 || out_data !== 8'h00 || out_dst !== 2'd0 || out_last !== 1'b0) begin miscompares++; $display("FAIL rstmid_outs: got rdy %b data %h dst %0d last %b", in_ready, out_data, out_dst, out_last); end
        @(negedge clk);
        reset_n = 1'b1;
        send_beat(8'hB7, 2'd1, 1'b1);
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'hB7 || out_dst !== 2'd1 || out_last !== 1'b1) begin miscompares++; $display("FAIL rstmid_new: got %b %h %0d %b want 1 b7 1 1", out_valid, out_data, out_dst, out_last); end
        vectors++; if (pkt_count !== 5'd1) begin miscompares++; $display("FAIL rstmid_new_count: got %0d want 1", pkt_count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0 || pkt_count !== 5'd0) begin miscompares++; $display("FAIL rstmid_alone: got valid %b count %0d want 0/0", out_valid, pkt_count); end
    endtask

`ifdef INGRESS_DROP_EN
    task automatic test_drop();
        logic [7:0] exp_data;
        logic [1:0] exp_dst;
        out_ready = 1'b0;
        for (int i = 0; i < 14; i++) send_beat(8'hC0 + 8'(i), 2'(i / 7), (i % 7) == 6);
        vectors++; if (pkt_count !== 5'd2) begin miscompares++; $display("FAIL drop_pre_count: got %0d want 2", pkt_count); end
        for (int i = 0; i < 5; i++) send_beat(8'hD0 + 8'(i), 2'd2, i == 4);
        vectors++; if (drop_count !== 16'd1) begin miscompares++; $display("FAIL drop_count: got %0d want 1", drop_count); end
        vectors++; if (pkt_count !== 5'd2) begin miscompares++; $display("FAIL drop_pkt_count: got %0d want 2", pkt_count); end
        send_beat(8'hE0, 2'd3, 1'b0);
        send_beat(8'hE1, 2'd3, 1'b1);
        vectors++; if (pkt_count !== 5'd3) begin miscompares++; $display("FAIL drop_after_count: got %0d want 3", pkt_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_data = (i < 14) ? 8'hC0 + 8'(i) : 8'hE0 + 8'(i - 14);
            exp_dst  = (i < 14) ? 2'(i / 7) : 2'd3;
            vectors++; if (out_data !== exp_data || out_dst !== exp_dst) begin miscompares++; $display("FAIL drop_drain[%0d]: got %h/%0d want %h/%0d", i, out_data, out_dst, exp_data, exp_dst); end
            step();
        end
        out_ready = 1'b0;
        vectors++; if (pkt_count !== 5'd0 || drop_count !== 16'd1) begin miscompares++; $display("FAIL drop_final: got count %0d drops %0d want 0/1", pkt_count, drop_count); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_fill_wrap();
        test_collide();
        test_reset_mid();
`ifdef INGRESS_DROP_EN
        test_drop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ingress_queue.md
Name: ingress_queue

Overview:
- Per-ingress-port store-and-forward packet buffer. It sits between the receive MAC/parser stream and the per-egress round-robin schedulers.
- Accepts beats with a destination port tag on each packet's first beat and stores whole packets.
- Presents the head packet to the schedulers as valid/last/dst, one bit-slice of their ingress vectors.
- Drains beats on the scheduler's ready; this is the requester end of the scheduler handshake.

Parameters:
- DATA_WIDTH, 8, beat payload width.
- IDX_WIDTH, 2, destination port index width (log2 of port count).
- DEPTH, 16, beat storage entries; power of two, minimum 2.
- ADDR_WIDTH, 4, log2(DEPTH).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_WIDTH  inbound beat payload.
- in_valid  in  1  inbound beat valid.
- in_last  in  1  final beat of packet.
- in_dst  in  IDX_WIDTH  destination egress; sampled only on a packet's first beat.
- in_ready  out  1  queue accepts beat.
- out_data  out  DATA_WIDTH  head beat payload.
- out_valid  out  1  head beat valid (drives scheduler ingress_valid).
- out_last  out  1  head beat is last (drives ingress_last).
- out_dst  out  IDX_WIDTH  head packet destination (drives ingress_dst).
- out_ready  in  1  scheduler ingress_ready; beat consumed when out_valid && out_ready.
- pkt_count  out  ADDR_WIDTH+1  complete packets stored.

Behaviour:
- Reset (asynchronous on reset_n low, any cycle, including mid-packet):
  - Pointers, pkt_count and descriptor FIFO cleared; input FSM to IN_HEAD.
  - Outputs: in_ready=1, out_valid=0, out_last=0, out_dst=0, out_data=0, pkt_count=0.
  - Partially received or partially drained packets are discarded.
- Beat FIFO:
  - DEPTH x {data,last}, ADDR_WIDTH+1-bit wr_ptr/rd_ptr with wrap bit.
  - full when addresses are equal and wrap bits differ; empty when the pointers are equal.
  - Pointers wrap modulo 2*DEPTH with no saturation.
- Descriptor FIFO:
  - DEPTH entries of IDX_WIDTH, since packets are at least one beat.
  - Written with in_dst on each accepted first beat; popped when the last beat is read.
- Input FSM:
  - IN_HEAD: accepted beat with in_last=0 -> IN_BODY; with in_last=1 -> stay, single-beat packet.
  - IN_BODY: accepted beat with in_last=1 -> IN_HEAD.
  - in_ready = !full. The beat is accepted when in_valid && in_ready.
- Commit: the cycle after an accepted in_last beat, pkt_count increments. Packet data is visible one cycle after its last beat is written.
- Output:
  - out_valid = (pkt_count != 0), so there are no bubbles within a packet.
  - out_data/out_last are read from mem[rd_ptr] combinationally; out_dst is the descriptor head.
  - On a handshake, rd_ptr advances. If out_last=1, pkt_count decrements and the descriptor pops.
- Simultaneous commit and drain of a last beat in the same cycle: pkt_count unchanged.
- A beat may be written and read in the same cycle when not full/empty. A read frees space that is visible to in_ready the next cycle.
- pkt_count never exceeds DEPTH.
- Without the optional feature, packets longer than DEPTH beats are illegal and deadlock. The bench must not generate them.
- out_valid held while out_ready low: out_data/out_last/out_dst remain stable.

Optional Feature:
- Macro INGRESS_DROP_EN.
- When defined:
  - in_ready is tied to 1.
  - A commit pointer records wr_ptr at each packet start.
  - If a beat arrives while full, wr_ptr rewinds to the commit pointer and the descriptor write is cancelled. The FSM enters IN_DROP and discards beats until in_last inclusive, then returns to IN_HEAD.
  - Extra output port drop_count (16 bits, reset 0, saturating at 0xFFFF) increments once per dropped packet.
- When undefined: no IN_DROP state, no drop_count port, backpressure via in_ready as above.

Test Plan:
- Single-beat packet: in_data=0xA5, in_dst=2, in_last=1, out_ready=1 -> out_valid rises next cycle with out_data=0xA5, out_dst=2, out_last=1; after the handshake, pkt_count returns to 0.
- Back-to-back 3-beat packets (dst 1 then dst 3), out_ready=0 -> pkt_count=2. Raising out_ready drains 6 beats in order; out_dst=1 for beats 0-2 and 3 for beats 3-5; out_last only on beats 2 and 5.
- Fill DEPTH=16 beats as 4x4-beat packets with out_ready=0 -> in_ready=0 after the 16th accept. One drain handshake -> in_ready=1 next cycle; pointers wrap correctly across a further 32 beats.
- Commit and drain collide: last beat of packet B written in the same cycle packet A's last beat is read -> pkt_count stays 1 and out_dst switches to B's dst.
- Assert reset_n low mid-packet (2 of 4 beats in, 1 packet stored) -> outputs immediately at reset values. After release, a new 1-beat packet emerges alone.
- INGRESS_DROP_EN: with 14 beats stored, send a 5-beat packet -> it is dropped entirely, drop_count=1, pkt_count unchanged, and a following 2-beat packet is stored and delivered intact.
